// File: rtl/add_sub_pkg.sv
`default_nettype none
// ============================================================================
// Module  : add_sub_pkg
// Brief   : Shared constants, FSM state type and width check for the serial
//           add/sub controller.
// Revision: 1.0 - initial release
// ============================================================================
package add_sub_pkg;

   localparam int SLICE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Operand width must split evenly into slices and give at least two of them
   function automatic bit width_ok(input int w);
      return ((w % SLICE_W) == 0) && (w >= 2 * SLICE_W);
   endfunction

endpackage
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
// Module  : full_adder
// Brief   : Single-bit full adder cell.
// Revision: 1.0 - initial release
// ============================================================================
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule
`default_nettype wire

// File: rtl/nibble_add_sub.sv
`default_nettype none
// ============================================================================
// Module  : nibble_add_sub
// Brief   : 4-bit ripple add/sub slice with an explicit carry-in so slices
//           can be chained through an external carry register.
// Revision: 1.0 - initial release
// ============================================================================
module nibble_add_sub
   import add_sub_pkg::*;
(
   input  logic [SLICE_W-1:0] a,
   input  logic [SLICE_W-1:0] b,
   input  logic               sub,
   input  logic               cin,
   output logic [SLICE_W-1:0] sum,
   output logic               cout,
   output logic               c3
);

   logic [SLICE_W-1:0] w_b_eff;
   logic [SLICE_W:0]   w_c;

   assign w_b_eff = b ^ {SLICE_W{sub}};
   assign w_c[0]  = cin;

   for (genvar gi = 0; gi < SLICE_W; gi++) begin : g_fa
      full_adder u_fa (
         .a    (a[gi]),
         .b    (w_b_eff[gi]),
         .cin  (w_c[gi]),
         .s    (sum[gi]),
         .cout (w_c[gi+1])
      );
   end

   assign cout = w_c[SLICE_W];
   assign c3   = w_c[SLICE_W-1];

endmodule
`default_nettype wire

// File: rtl/serial_add_sub_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : serial_add_sub_ctrl
// Brief   : WIDTH-bit add/sub done LS nibble first over WIDTH/4 cycles on one
//           shared 4-bit slice, with valid/ready handshakes on both sides.
// Revision: 1.0 - initial release
// ============================================================================
module serial_add_sub_ctrl
   import add_sub_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             overflow,
   output logic             busy
);

   localparam int c_num_slices = WIDTH / SLICE_W;
   localparam int c_idx_w      = $clog2(c_num_slices);
   localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(c_num_slices - 1);

   if (!width_ok(WIDTH)) begin : g_width_chk
      $error("serial_add_sub_ctrl: WIDTH must be a multiple of 4 and >= 8");
   end

   state_t             r_state;
   state_t             w_state_next;
   logic [c_idx_w-1:0] r_idx;
   logic               r_c;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic               r_sub;
   logic [WIDTH-1:0]   r_result;
   logic               r_carry;
   logic               r_overflow;

   logic [c_idx_w+1:0] w_base;
   logic [SLICE_W-1:0] w_a_sl;
   logic [SLICE_W-1:0] w_b_sl;
   logic [SLICE_W-1:0] w_sum;
   logic               w_cout;
   logic               w_c3;
   logic               w_last;

   // Slice base bit offset is idx * 4
   assign w_base = {r_idx, 2'b00};
   assign w_a_sl = r_a[w_base +: SLICE_W];
   assign w_b_sl = r_b[w_base +: SLICE_W];
   assign w_last = (r_idx == c_last_idx);

   nibble_add_sub u_slice (
      .a    (w_a_sl),
      .b    (w_b_sl),
      .sub  (r_sub),
      .cin  (r_c),
      .sum  (w_sum),
      .cout (w_cout),
      .c3   (w_c3)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (in_valid)  w_state_next = RUN;
         RUN:     if (w_last)    w_state_next = DONE;
         DONE:    if (out_ready) w_state_next = IDLE;
         default:                w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_idx      <= '0;
         r_c        <= 1'b0;
         r_a        <= '0;
         r_b        <= '0;
         r_sub      <= 1'b0;
         r_result   <= '0;
         r_carry    <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_a   <= a;
                  r_b   <= b;
                  r_sub <= sub;
                  r_c   <= sub;
                  r_idx <= '0;
               end
            end
            RUN: begin
               r_result[w_base +: SLICE_W] <= w_sum;
               r_c <= w_cout;
               if (w_last) begin
                  r_idx      <= '0;
                  r_carry    <= w_cout;
                  r_overflow <= w_c3 ^ w_cout;
               end else begin
                  r_idx <= r_idx + c_idx_w'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == DONE);
   assign busy      = (r_state != IDLE);
   assign result    = r_result;
   assign carry     = r_carry;
   assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_sub_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_serial_add_sub_ctrl
// Brief   : Directed self-checking bench for serial_add_sub_ctrl (WIDTH=16).
// Revision: 1.0 - initial release
// ============================================================================
module tb_serial_add_sub_ctrl;

   localparam int WIDTH = 16;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             carry;
   logic             overflow;
   logic             busy;

   int n_checks = 0;
   int n_pass   = 0;

   serial_add_sub_ctrl #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .carry     (carry),
      .overflow  (overflow),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one operation, wait for the result, compare, then release it
   task automatic do_op(input string tag, input logic [15:0] op_a, input logic [15:0] op_b,
                        input logic op_sub, input logic [15:0] exp_res,
                        input logic exp_c, input logic exp_v);
      int lat;
      check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      a        = op_a;
      b        = op_b;
      sub      = op_sub;
      tick();
      in_valid = 1'b0;
      a        = 16'h0;
      b        = 16'h0;
      sub      = 1'b0;
      lat      = 0;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      check({tag, "_latency"}, 32'(lat), 32'd4);
      check({tag, "_result"},  32'(result),   32'(exp_res));
      check({tag, "_carry"},   32'(carry),    32'(exp_c));
      check({tag, "_ovf"},     32'(overflow), 32'(exp_v));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, "_release"}, 32'({in_ready, out_valid, busy}), 32'b100);
   endtask

   initial begin
      int seen;
      rst       = 1'b1;
      in_valid  = 1'b0;
      a         = 16'h0;
      b         = 16'h0;
      sub       = 1'b0;
      out_ready = 1'b0;
      tick();
      tick();
      check("reset_flags",  32'({in_ready, out_valid, busy}), 32'b100);
      check("reset_result", 32'({result, carry, overflow}), 32'h0);
      rst = 1'b0;
      tick();

      do_op("add_1234_0fff", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
      do_op("sub_5_7",       16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      do_op("sub_7_5",       16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0);
      do_op("add_7fff_1",    16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
      do_op("sub_8000_1",    16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
      do_op("add_ffff_1",    16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);

      // Backpressure: hold result for 5 cycles while a new request is offered
      in_valid = 1'b1;
      a        = 16'h00FF;
      b        = 16'h0001;
      sub      = 1'b0;
      tick();
      in_valid = 1'b0;
      seen     = 0;
      while (!out_valid && seen < 20) begin
         tick();
         seen++;
      end
      check("bp_latency", 32'(seen), 32'd4);
      in_valid = 1'b1;
      a        = 16'hAAAA;
      b        = 16'h5555;
      sub      = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_hold_result", 32'({result, carry, overflow}), 32'({16'h0100, 1'b0, 1'b0}));
         check("bp_hold_flags",  32'({in_ready, out_valid, busy}), 32'b011);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("bp_release", 32'({in_ready, out_valid, busy}), 32'b100);
      tick();
      check("bp_no_second_op", 32'({in_ready, busy}), 32'b10);

      // Reset while RUN is on idx 2
      in_valid = 1'b1;
      a        = 16'h1111;
      b        = 16'h2222;
      sub      = 1'b0;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_flags",  32'({in_ready, out_valid, busy}), 32'b100);
      check("abort_result", 32'({result, carry, overflow}), 32'h0);
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (out_valid) seen++;
      end
      check("abort_no_output", 32'(seen), 32'd0);
      do_op("add_1_1_after_abort", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/serial_add_sub_ctrl.md
# serial_add_sub_ctrl

Multi-cycle controller that performs WIDTH-bit add/subtract by sequencing one shared 4-bit ripple-carry add/sub slice over WIDTH/4 cycles, least-significant nibble first. The carry/borrow is held in a register between cycles. Operands enter through a valid/ready handshake and the result leaves through one. It sits between a requester and the nibble datapath, trading latency for a 4-bit adder footprint.

## Interface
- WIDTH, 16, operand/result width; multiple of 4, ≥ 8
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand request
- in_ready  out  1  controller can accept (IDLE only)
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- sub  in  1  0 = A+B, 1 = A−B
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  sum/difference, two's complement
- carry  out  1  carry-out of MSB; for subtract, 1 = no borrow (A ≥ B unsigned)
- overflow  out  1  signed overflow
- busy  out  1  high in RUN or DONE

One clock; reset is synchronous and active-high.

## Operation
- N = WIDTH/4 slices. idx counter is ceil(log2 N) bits wide.
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. When in_valid && in_ready:
  - latch a, b, sub
  - c_reg ← sub
  - idx ← 0
  - go to RUN
- RUN: slice computes a[4i+3:4i] + (b[4i+3:4i] ^ {4{sub}}) + c_reg, where i = idx.
  - Write the 4-bit sum into result[4i+3:4i]; c_reg ← slice cout; idx ← idx+1.
  - At idx == N−1:
    - carry ← slice cout
    - overflow ← slice carry-into-bit-3 XOR slice cout
    - go to DONE
- DONE: out_valid=1; result, carry and overflow are held stable. When out_ready, go to IDLE.
- Operand inputs are ignored outside the IDLE handshake. in_valid in RUN/DONE has no effect.
- Arithmetic is modulo 2^WIDTH. The inverted-B plus carry-in-of-sub form gives the two's-complement subtract.
- Reset values:
  - state IDLE, idx 0, c_reg 0
  - result 0, carry 0, overflow 0
  - out_valid 0, busy 0
  - in_ready 1 from the first cycle after reset
- Reset mid-operation (RUN or DONE) aborts with no output. The next cycle is IDLE with reset values.
- Simultaneous rst and handshake: rst wins and the operation is not accepted.
- Result slices not yet written during RUN are don't-care. Only values sampled while out_valid=1 are defined.

## Timing
- Accept on edge k. RUN occupies edges k+1 … k+N. out_valid is high from edge k+N.
  - WIDTH=16: result visible 4 cycles after accept.
- DONE→IDLE on the edge where out_valid && out_ready. in_ready is high the following cycle.
- Minimum initiation interval is N+2 cycles. There is no overlap between operations.
- out_valid stays high indefinitely under backpressure. The result does not change while held.
- in_ready, out_valid and busy are decoded from registered state, with no combinational path from inputs.

## Structure
- Package add_sub_pkg holds:
  - SLICE_W = 4
  - state enum {IDLE, RUN, DONE}
  - a static check that WIDTH % SLICE_W == 0
- Sub-module nibble_add_sub is a 4-bit ripple add/sub.
  - Inputs: a, b, sub, cin.
  - Outputs: sum, cout, c3 (carry into bit 3).
  - Unlike the existing 4-bit add/sub, cin is an explicit port rather than tied to sub, so the slice can be chained through c_reg.
  - Built from the existing full_adder cells.
- The controller instantiates exactly one nibble_add_sub and muxes slices by idx.

## Test plan
- Add 0x1234 + 0x0FFF → result 0x2233, carry 0, overflow 0. out_valid exactly 4 cycles after accept.
- Sub 0x0005 − 0x0007 → 0xFFFE, carry 0 (borrow), overflow 0. Sub 0x0007 − 0x0005 → 0x0002, carry 1.
- Add 0x7FFF + 0x0001 → 0x8000, overflow 1, carry 0. Sub 0x8000 − 0x0001 → 0x7FFF, overflow 1, carry 1.
- Add 0xFFFF + 0x0001 → 0x0000, carry 1, overflow 0. This proves the carry propagates through all 4 slices via c_reg.
- Backpressure: out_ready low for 5 cycles after out_valid.
  - result, carry and overflow hold.
  - in_ready stays 0, and a new in_valid with different operands is ignored.
  - Raising out_ready releases the result; in_ready=1 the next cycle.
- Assert rst during RUN at idx=2 → next cycle IDLE, out_valid 0, busy 0, in_ready 1, result 0, and no result is ever emitted. A following add 0x0001 + 0x0001 returns 0x0002.
